// File: rtl/sha3_absorb_sched_pkg.sv
// Shared types and constants for the encapsulation hash sequencing path.
package hash_ctrl_pkg;

   // Controller states
   typedef enum logic [2:0] {
      IDLE,
      FILL,
      PAD,
      PERM,
      WAIT,
      FINISH
   } state_t;

   // Rate geometry: one 1088-bit block is 68 packed 16-bit words
   localparam int RATE_WORDS = 68;
   localparam int WORD_BITS  = 16;
   localparam int RATE_BITS  = RATE_WORDS * WORD_BITS;

   // Pad bytes inserted by the datapath (domain byte on the first pad word, end bit on the last block)
   localparam logic [7:0] PAD_FIRST_BYTE = 8'h06;
   localparam logic [7:0] PAD_LAST_BYTE  = 8'h80;

endpackage

// File: rtl/sha3_absorb_sched_rate_word_counter.sv
// Counts words shifted into the rate buffer for the block being assembled.
module rate_word_counter #(
   parameter int RATE_WORDS = 68,
   parameter int CNT_W      = 7
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   output logic full
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATE_WORDS - 1);

   logic [CNT_W-1:0] cnt;

   // full marks the increment that brings the count to RATE_WORDS, so the
   // controller can leave on the same edge that stores the last word
   assign full = inc && (cnt == LAST_CNT);

   // Word count; clear has priority over increment
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/sha3_absorb_sched.sv
// Absorb sequencer: paces message words into the rate buffer, pads the tail
// and issues one permutation request per 1088-bit block.
module sha3_absorb_sched #(
   parameter int RATE_WORDS = hash_ctrl_pkg::RATE_WORDS,
   parameter int MAX_BLOCKS = 4,
   parameter int CNT_W      = 7
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic       in_valid,
   input  logic       in_last,
   output logic       in_ready,
   output logic       buf_clr,
   output logic       buf_shift,
   output logic       buf_zero,
   output logic       pad_first,
   output logic       perm_start,
   output logic       perm_first,
   output logic       perm_fin,
   input  logic       perm_done,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [2:0] blk_cnt
);

   import hash_ctrl_pkg::*;

   localparam logic [2:0] MAX_BLK = 3'(MAX_BLOCKS);

   state_t state;
   logic   first_f;   // next permutation is the first of the message
   logic   end_f;     // last message word has been accepted
   logic   fin_f;     // block being assembled is the final padded block
   logic   pad_seen;  // a pad word has already been shifted for this message
   logic   wc_clr;
   logic   wc_full;
   logic   blk_ovf;

   // A fifth block would overflow the message limit
   assign blk_ovf = (blk_cnt == MAX_BLK);
   assign busy    = (state != IDLE);

   // Word counter restarts on a new message, after each block and on abort
   assign wc_clr = abort || (state == PERM) || ((state == IDLE) && start);

   rate_word_counter #(
      .RATE_WORDS (RATE_WORDS),
      .CNT_W      (CNT_W)
   ) u_wcnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (wc_clr),
      .inc   (buf_shift),
      .full  (wc_full)
   );

   // Buffer and permutation controls decoded from the current state
   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      in_ready   = 1'b0;
      buf_clr    = 1'b0;
      buf_shift  = 1'b0;
      buf_zero   = 1'b0;
      pad_first  = 1'b0;
      perm_start = 1'b0;
      perm_first = 1'b0;
      perm_fin   = 1'b0;
      done       = 1'b0;
      if (abort) begin
         buf_clr = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               buf_clr = start;
            end
            FILL: begin
               in_ready  = 1'b1;
               buf_shift = in_valid;
            end
            PAD: begin
               buf_shift = 1'b1;
               buf_zero  = 1'b1;
               pad_first = !pad_seen;
            end
            PERM: begin
               if (!blk_ovf) begin
                  perm_start = 1'b1;
                  perm_first = first_f;
                  perm_fin   = fin_f;
               end
            end
            FINISH: begin
               done = 1'b1;
            end
            default: begin
               done = 1'b0;
            end
         endcase
      end
   end

   // Sequencing state, block count and message flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         blk_cnt  <= '0;
         err      <= 1'b0;
         first_f  <= 1'b0;
         end_f    <= 1'b0;
         fin_f    <= 1'b0;
         pad_seen <= 1'b0;
      end else if (abort) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  blk_cnt  <= '0;
                  err      <= 1'b0;
                  first_f  <= 1'b1;
                  end_f    <= 1'b0;
                  fin_f    <= 1'b0;
                  pad_seen <= 1'b0;
                  state    <= FILL;
               end
            end
            FILL: begin
               if (in_valid) begin
                  if (in_last) begin
                     end_f <= 1'b1;
                  end
                  if (wc_full) begin
                     state <= PERM;
                  end else if (in_last) begin
                     state <= PAD;
                  end
               end
            end
            PAD: begin
               pad_seen <= 1'b1;
               if (wc_full) begin
                  fin_f <= 1'b1;
                  state <= PERM;
               end
            end
            PERM: begin
               if (blk_ovf) begin
                  err   <= 1'b1;
                  state <= IDLE;
               end else begin
                  blk_cnt <= blk_cnt + 3'd1;
                  state   <= WAIT;
               end
            end
            WAIT: begin
               if (perm_done) begin
                  first_f <= 1'b0;
                  if (fin_f) begin
                     state <= FINISH;
                  end else if (end_f) begin
                     state <= PAD;
                  end else begin
                     state <= FILL;
                  end
               end
            end
            FINISH: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sha3_absorb_sched.sv
// Directed bench for the absorb sequencer: message lengths around the block
// boundary, handshake gaps, block overflow, abort and reset.
module tb_sha3_absorb_sched;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       abort;
   logic       in_valid;
   logic       in_last;
   logic       in_ready;
   logic       buf_clr;
   logic       buf_shift;
   logic       buf_zero;
   logic       pad_first;
   logic       perm_start;
   logic       perm_first;
   logic       perm_fin;
   logic       perm_done;
   logic       busy;
   logic       done;
   logic       err;
   logic [2:0] blk_cnt;

   int n_checks = 0;
   int n_errors = 0;
   int perm_delay = 0;

   // Cumulative event counts seen on the DUT outputs
   int n_dshift = 0;
   int n_zshift = 0;
   int n_pf     = 0;
   int pf_at    = -1;
   int n_perm   = 0;
   int n_done   = 0;
   int n_bad    = 0;
   bit perm_first_log [64];
   bit perm_fin_log   [64];

   sha3_absorb_sched dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .abort      (abort),
      .in_valid   (in_valid),
      .in_last    (in_last),
      .in_ready   (in_ready),
      .buf_clr    (buf_clr),
      .buf_shift  (buf_shift),
      .buf_zero   (buf_zero),
      .pad_first  (pad_first),
      .perm_start (perm_start),
      .perm_first (perm_first),
      .perm_fin   (perm_fin),
      .perm_done  (perm_done),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .blk_cnt    (blk_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Output monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (rst_n) begin
         if (buf_shift && buf_zero) begin
            if (pad_first) pf_at = n_zshift;
            n_zshift++;
         end else if (buf_shift) begin
            n_dshift++;
            if (!(in_valid && in_ready)) n_bad++;
         end
         if (pad_first) n_pf++;
         if (perm_start) begin
            if (n_perm < 64) begin
               perm_first_log[n_perm] = perm_first;
               perm_fin_log[n_perm]   = perm_fin;
            end
            n_perm++;
         end
         if (done) n_done++;
      end
   end

   // Permutation core model: one-cycle perm_done, perm_delay cycles after perm_start
   initial begin
      perm_done = 1'b0;
      forever begin
         @(negedge clk);
         if (perm_start) begin
            repeat (perm_delay + 1) @(negedge clk);
            perm_done = 1'b1;
            @(negedge clk);
            perm_done = 1'b0;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Start a message of n words and run it until done or return to IDLE.
   // Cycle 0 is the cycle start is presented; lat is the cycle done is seen.
   task automatic run_msg(input int n, input bit with_last, input bit gaps,
                          input int delay, input bit mid_start,
                          output bit ended, output int lat);
      int sent;
      int cyc;
      perm_delay = delay;
      ended = 1'b0;
      lat   = -1;
      sent  = 0;
      cyc   = 0;
      @(posedge clk); #1;
      while (!ended && cyc < 2000) begin
         start = (cyc == 0) || (mid_start && cyc == 10);
         if (sent < n) begin
            in_valid = !(gaps && ($urandom_range(0, 2) == 0));
            in_last  = with_last && in_valid && (sent == n - 1);
         end else begin
            in_valid = 1'b0;
            in_last  = 1'b0;
         end
         @(negedge clk);
         if (in_valid && in_ready) sent++;
         if (done) begin
            lat   = cyc;
            ended = 1'b1;
         end else if (cyc > 0 && !busy) begin
            ended = 1'b1;
         end
         @(posedge clk); #1;
         cyc++;
      end
      start    = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic test_reset;
      #2;
      n_checks++;
      if ({in_ready, buf_clr, buf_shift, buf_zero, pad_first, perm_start, perm_first,
           perm_fin, busy, done, err} !== 11'b0) begin
         n_errors++;
         $display("FAIL reset_outputs: got %b expected all zero",
                  {in_ready, buf_clr, buf_shift, buf_zero, pad_first, perm_start,
                   perm_first, perm_fin, busy, done, err});
      end
      n_checks++;
      if (blk_cnt !== 3'd0) begin
         n_errors++;
         $display("FAIL reset_blk_cnt: got %0d expected 0", blk_cnt);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({busy, in_ready, err, done} !== 4'b0) begin
         n_errors++;
         $display("FAIL reset_release_idle: got %b expected 0000", {busy, in_ready, err, done});
      end
   endtask

   task automatic test_one_word;
      bit ended;
      int lat;
      int d0 = n_dshift, z0 = n_zshift, f0 = n_pf, p0 = n_perm, o0 = n_done;
      run_msg(1, 1'b1, 1'b0, 10, 1'b0, ended, lat);
      n_checks++;
      if (lat !== 81) begin
         n_errors++;
         $display("FAIL one_word_done_cycle: got %0d expected 81", lat);
      end
      n_checks++;
      if (n_dshift - d0 !== 1) begin
         n_errors++;
         $display("FAIL one_word_data_shifts: got %0d expected 1", n_dshift - d0);
      end
      n_checks++;
      if (n_zshift - z0 !== 67) begin
         n_errors++;
         $display("FAIL one_word_zero_shifts: got %0d expected 67", n_zshift - z0);
      end
      n_checks++;
      if (n_pf - f0 !== 1 || pf_at !== z0) begin
         n_errors++;
         $display("FAIL one_word_pad_first: got count %0d at %0d expected 1 at %0d",
                  n_pf - f0, pf_at, z0);
      end
      n_checks++;
      if (n_perm - p0 !== 1 || {perm_first_log[p0], perm_fin_log[p0]} !== 2'b11) begin
         n_errors++;
         $display("FAIL one_word_perm: got %0d starts first/fin=%b%b expected 1 start 11",
                  n_perm - p0, perm_first_log[p0], perm_fin_log[p0]);
      end
      n_checks++;
      if (n_done - o0 !== 1 || blk_cnt !== 3'd1) begin
         n_errors++;
         $display("FAIL one_word_done_blk: got done %0d blk %0d expected 1 and 1",
                  n_done - o0, blk_cnt);
      end
   endtask

   task automatic test_latency;
      bit ended;
      int lat;
      run_msg(1, 1'b1, 1'b0, 0, 1'b0, ended, lat);
      n_checks++;
      if (lat !== 71) begin
         n_errors++;
         $display("FAIL latency_1word: got %0d expected 71", lat);
      end
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_errors++;
         $display("FAIL latency_back_idle: got busy %b done %b expected 0 0", busy, done);
      end
   endtask

   task automatic test_block_boundary;
      bit ended;
      int lat;
      int d0 = n_dshift, z0 = n_zshift, f0 = n_pf, p0 = n_perm, o0 = n_done;
      run_msg(68, 1'b1, 1'b0, 2, 1'b0, ended, lat);
      n_checks++;
      if (!ended || n_done - o0 !== 1) begin
         n_errors++;
         $display("FAIL w68_done: got ended %b done %0d expected 1 1", ended, n_done - o0);
      end
      n_checks++;
      if (n_dshift - d0 !== 68 || n_zshift - z0 !== 68) begin
         n_errors++;
         $display("FAIL w68_shifts: got data %0d zero %0d expected 68 68",
                  n_dshift - d0, n_zshift - z0);
      end
      n_checks++;
      if (n_pf - f0 !== 1 || pf_at !== z0) begin
         n_errors++;
         $display("FAIL w68_pad_first: got count %0d at %0d expected 1 at %0d",
                  n_pf - f0, pf_at, z0);
      end
      n_checks++;
      if (n_perm - p0 !== 2 ||
          {perm_first_log[p0], perm_fin_log[p0], perm_first_log[p0+1], perm_fin_log[p0+1]} !== 4'b1001) begin
         n_errors++;
         $display("FAIL w68_perm_flags: got %0d starts flags %b%b_%b%b expected 2 starts 10_01",
                  n_perm - p0, perm_first_log[p0], perm_fin_log[p0],
                  perm_first_log[p0+1], perm_fin_log[p0+1]);
      end
      n_checks++;
      if (blk_cnt !== 3'd2) begin
         n_errors++;
         $display("FAIL w68_blk_cnt: got %0d expected 2", blk_cnt);
      end
   endtask

   task automatic test_gaps;
      bit ended;
      int lat;
      int d0 = n_dshift, z0 = n_zshift, p0 = n_perm, b0 = n_bad, o0 = n_done;
      run_msg(69, 1'b1, 1'b1, 3, 1'b0, ended, lat);
      n_checks++;
      if (!ended || n_done - o0 !== 1) begin
         n_errors++;
         $display("FAIL w69_done: got ended %b done %0d expected 1 1", ended, n_done - o0);
      end
      n_checks++;
      if (n_dshift - d0 !== 69 || n_zshift - z0 !== 67) begin
         n_errors++;
         $display("FAIL w69_shifts: got data %0d zero %0d expected 69 67",
                  n_dshift - d0, n_zshift - z0);
      end
      n_checks++;
      if (n_bad - b0 !== 0) begin
         n_errors++;
         $display("FAIL w69_shift_without_valid: got %0d expected 0", n_bad - b0);
      end
      n_checks++;
      if (n_perm - p0 !== 2 ||
          {perm_first_log[p0], perm_fin_log[p0], perm_first_log[p0+1], perm_fin_log[p0+1]} !== 4'b1001) begin
         n_errors++;
         $display("FAIL w69_perm_flags: got %0d starts flags %b%b_%b%b expected 2 starts 10_01",
                  n_perm - p0, perm_first_log[p0], perm_fin_log[p0],
                  perm_first_log[p0+1], perm_fin_log[p0+1]);
      end
      n_checks++;
      if (blk_cnt !== 3'd2) begin
         n_errors++;
         $display("FAIL w69_blk_cnt: got %0d expected 2", blk_cnt);
      end
   endtask

   task automatic test_overflow;
      bit ended;
      int lat;
      int d0 = n_dshift, p0 = n_perm, o0 = n_done;
      run_msg(340, 1'b0, 1'b0, 2, 1'b0, ended, lat);
      @(negedge clk);
      n_checks++;
      if (!ended || busy !== 1'b0 || err !== 1'b1) begin
         n_errors++;
         $display("FAIL ovf_err_idle: got ended %b busy %b err %b expected 1 0 1", ended, busy, err);
      end
      n_checks++;
      if (n_perm - p0 !== 4 || n_done - o0 !== 0) begin
         n_errors++;
         $display("FAIL ovf_perm_count: got starts %0d done %0d expected 4 0",
                  n_perm - p0, n_done - o0);
      end
      n_checks++;
      if ({perm_first_log[p0], perm_first_log[p0+1], perm_first_log[p0+2], perm_first_log[p0+3],
           perm_fin_log[p0], perm_fin_log[p0+1], perm_fin_log[p0+2], perm_fin_log[p0+3]} !== 8'b1000_0000) begin
         n_errors++;
         $display("FAIL ovf_perm_flags: got first %b%b%b%b fin %b%b%b%b expected 1000 0000",
                  perm_first_log[p0], perm_first_log[p0+1], perm_first_log[p0+2], perm_first_log[p0+3],
                  perm_fin_log[p0], perm_fin_log[p0+1], perm_fin_log[p0+2], perm_fin_log[p0+3]);
      end
      n_checks++;
      if (n_dshift - d0 !== 340 || blk_cnt !== 3'd4) begin
         n_errors++;
         $display("FAIL ovf_words_blk: got data %0d blk %0d expected 340 4", n_dshift - d0, blk_cnt);
      end
   endtask

   task automatic test_abort;
      int p0, o0;
      // abort together with start while IDLE: clear pulse, start ignored, err kept
      @(posedge clk); #1;
      abort = 1'b1;
      start = 1'b1;
      @(negedge clk);
      n_checks++;
      if (buf_clr !== 1'b1) begin
         n_errors++;
         $display("FAIL abort_idle_clr: got %b expected 1", buf_clr);
      end
      @(posedge clk); #1;
      abort = 1'b0;
      start = 1'b0;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || err !== 1'b1) begin
         n_errors++;
         $display("FAIL abort_start_ignored: got busy %b err %b expected 0 1", busy, err);
      end
      // abort while padding a 1-word message
      p0 = n_perm;
      o0 = n_done;
      perm_delay = 0;
      @(posedge clk); #1;
      start    = 1'b1;
      in_valid = 1'b1;
      in_last  = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (buf_zero !== 1'b1 || busy !== 1'b1) begin
         n_errors++;
         $display("FAIL abort_pre_pad: got buf_zero %b busy %b expected 1 1", buf_zero, busy);
      end
      @(posedge clk); #1;
      abort = 1'b1;
      @(negedge clk);
      n_checks++;
      if (buf_clr !== 1'b1 || done !== 1'b0) begin
         n_errors++;
         $display("FAIL abort_pad_clr: got buf_clr %b done %b expected 1 0", buf_clr, done);
      end
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin
         n_errors++;
         $display("FAIL abort_pad_idle: got busy %b expected 0", busy);
      end
      repeat (80) @(negedge clk);
      n_checks++;
      if (n_perm - p0 !== 0 || n_done - o0 !== 0 || err !== 1'b0) begin
         n_errors++;
         $display("FAIL abort_no_activity: got starts %0d done %0d err %b expected 0 0 0",
                  n_perm - p0, n_done - o0, err);
      end
   endtask

   task automatic test_reset_in_wait;
      int k = 0;
      perm_delay = 30;
      @(posedge clk); #1;
      start    = 1'b1;
      in_valid = 1'b1;
      in_last  = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      while (perm_start !== 1'b1 && k < 200) begin
         @(negedge clk);
         k++;
      end
      n_checks++;
      if (perm_start !== 1'b1) begin
         n_errors++;
         $display("FAIL rst_wait_perm_start: got timeout after %0d cycles expected perm_start", k);
      end
      @(posedge clk); #3;
      n_checks++;
      if (busy !== 1'b1 || blk_cnt !== 3'd1) begin
         n_errors++;
         $display("FAIL rst_wait_pre: got busy %b blk %0d expected 1 1", busy, blk_cnt);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({in_ready, buf_clr, buf_shift, buf_zero, pad_first, perm_start, perm_first,
           perm_fin, busy, done, err, blk_cnt} !== 14'b0) begin
         n_errors++;
         $display("FAIL rst_wait_outputs: got %b expected all zero",
                  {in_ready, buf_clr, buf_shift, buf_zero, pad_first, perm_start, perm_first,
                   perm_fin, busy, done, err, blk_cnt});
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (45) @(posedge clk);
   endtask

   task automatic test_busy_start;
      bit ended;
      int lat;
      int d0 = n_dshift, z0 = n_zshift, p0 = n_perm, o0 = n_done;
      run_msg(1, 1'b1, 1'b0, 0, 1'b1, ended, lat);
      n_checks++;
      if (lat !== 71) begin
         n_errors++;
         $display("FAIL busy_start_latency: got %0d expected 71", lat);
      end
      n_checks++;
      if (n_dshift - d0 !== 1 || n_zshift - z0 !== 67 || n_perm - p0 !== 1 || n_done - o0 !== 1) begin
         n_errors++;
         $display("FAIL busy_start_counts: got data %0d zero %0d perm %0d done %0d expected 1 67 1 1",
                  n_dshift - d0, n_zshift - z0, n_perm - p0, n_done - o0);
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      abort    = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      test_reset();
      test_one_word();
      test_latency();
      test_block_boundary();
      test_gaps();
      test_overflow();
      test_abort();
      test_reset_in_wait();
      test_busy_start();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
